// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop add two WIDTH-bit
// operands LSB first, then register sum/cout alongside a one-cycle done strobe.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fa;
  logic             last_bit;
  logic             accept;

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  assign fa       = full_add(a_sr[0], b_sr[0], carry);
  assign last_bit = (cnt == LAST);
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // The new sum bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nxt = fa[0];
    end else begin : g_wn
      assign res_nxt = {fa[0], res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Both flags decode straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      carry  <= fa[1];
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        sum  <= res_nxt;
        cout <= fa[1];
      end
    end
  end

endmodule
